mac_seq_ctrl: RTL

- Sequencer for the signed multiply-accumulate datapath. Computes one dot product per command.
- On START it latches a vector length and two base addresses, then streams operand reads from the data and weight memories.
- Drives an enable/clear-capable accumulator through the stream and presents the final sum on a valid/ready result port with a sticky overflow flag.
- Sits between the layer scheduler (command side) and the operand SRAMs plus downstream result consumer.

---
 rtl/mac_seq_ctrl_pkg.sv | 21 ++
 rtl/mac_seq_ctrl_if.sv | 40 ++++
 rtl/mac_seq_ctrl_acc.sv | 52 +++++
 rtl/mac_seq_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and width constants for the MAC sequencer slice.
package mac_ctrl_pkg;

   localparam int DEF_LEN_DATA_IN  = 8;
   localparam int DEF_LEN_WEIGHT   = 8;
   localparam int DEF_LEN_DATA_OUT = 18;
   localparam int DEF_LEN_ADDR     = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Full-precision signed product width.
   function automatic int prod_width(input int len_a, input int len_b);
      return len_a + len_b;
   endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command, operand-memory and result handshake bundle for mac_seq_ctrl.
interface mac_seq_ctrl_if
   import mac_ctrl_pkg::*;
#(
   parameter int LEN_DATA_IN  = DEF_LEN_DATA_IN,
   parameter int LEN_WEIGHT   = DEF_LEN_WEIGHT,
   parameter int LEN_DATA_OUT = DEF_LEN_DATA_OUT,
   parameter int LEN_ADDR     = DEF_LEN_ADDR
);

   logic                            START;
   logic [LEN_ADDR-1:0]             VEC_LEN;
   logic [LEN_ADDR-1:0]             BASE_ADDR_D;
   logic [LEN_ADDR-1:0]             BASE_ADDR_W;
   logic                            BUSY;
   logic                            RD_EN;
   logic [LEN_ADDR-1:0]             RD_ADDR_D;
   logic [LEN_ADDR-1:0]             RD_ADDR_W;
   logic signed [LEN_DATA_IN-1:0]   DATA_IN;
   logic signed [LEN_WEIGHT-1:0]    WEIGHT_INPUT;
   logic signed [LEN_DATA_OUT-1:0]  RESULT;
   logic                            OVF;
   logic                            RESULT_VALID;
   logic                            RESULT_READY;

   modport slave (
      input  START, VEC_LEN, BASE_ADDR_D, BASE_ADDR_W,
      input  DATA_IN, WEIGHT_INPUT, RESULT_READY,
      output BUSY, RD_EN, RD_ADDR_D, RD_ADDR_W,
      output RESULT, OVF, RESULT_VALID
   );

   modport master (
      output START, VEC_LEN, BASE_ADDR_D, BASE_ADDR_W,
      output DATA_IN, WEIGHT_INPUT, RESULT_READY,
      input  BUSY, RD_EN, RD_ADDR_D, RD_ADDR_W,
      input  RESULT, OVF, RESULT_VALID
   );

endinterface

// File: rtl/mac_seq_ctrl_acc.sv
// Signed multiply-accumulate register with synchronous clear/enable and
// sticky two's-complement overflow detection.
module mac_acc_unit
   import mac_ctrl_pkg::*;
#(
   parameter int LEN_DATA_IN  = DEF_LEN_DATA_IN,
   parameter int LEN_WEIGHT   = DEF_LEN_WEIGHT,
   parameter int LEN_DATA_OUT = DEF_LEN_DATA_OUT
)(
   input  logic                           CLK,
   input  logic                           ASYNC_RST,
   input  logic                           i_clr,
   input  logic                           i_en,
   input  logic signed [LEN_DATA_IN-1:0]  i_data,
   input  logic signed [LEN_WEIGHT-1:0]   i_weight,
   output logic signed [LEN_DATA_OUT-1:0] o_acc,
   output logic                           o_ovf
);

   localparam int LEN_PROD = prod_width(LEN_DATA_IN, LEN_WEIGHT);

   logic signed [LEN_PROD-1:0]     w_prod;
   logic signed [LEN_DATA_OUT-1:0] w_addend;
   logic signed [LEN_DATA_OUT-1:0] w_sum;
   logic                           w_add_ovf;
   logic signed [LEN_DATA_OUT-1:0] r_acc;
   logic                           r_ovf;

   assign w_prod   = LEN_PROD'(i_data) * LEN_PROD'(i_weight);
   assign w_addend = LEN_DATA_OUT'(w_prod);
   assign w_sum    = r_acc + w_addend;
   // Overflow: both addends share a sign that the wrapped sum does not.
   assign w_add_ovf = (r_acc[LEN_DATA_OUT-1] == w_addend[LEN_DATA_OUT-1]) &&
                      (w_sum[LEN_DATA_OUT-1] != r_acc[LEN_DATA_OUT-1]);

   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (i_en) begin
         r_acc <= w_sum;
         r_ovf <= r_ovf | w_add_ovf;
      end
   end

   assign o_acc = r_acc;
   assign o_ovf = r_ovf;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams N operand reads, drives the accumulator
// one cycle behind the reads, and hands the sum out on a valid/ready port.
module mac_seq_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int LEN_DATA_IN  = DEF_LEN_DATA_IN,
   parameter int LEN_WEIGHT   = DEF_LEN_WEIGHT,
   parameter int LEN_DATA_OUT = DEF_LEN_DATA_OUT,
   parameter int LEN_ADDR     = DEF_LEN_ADDR
)(
   input  logic          CLK,
   input  logic          ASYNC_RST,
   mac_seq_ctrl_if.slave bus
);

   state_t                         r_state;
   state_t                         w_next;
   logic [LEN_ADDR-1:0]            r_len;
   logic [LEN_ADDR-1:0]            r_cnt;
   logic [LEN_ADDR-1:0]            r_addr_d;
   logic [LEN_ADDR-1:0]            r_addr_w;
   logic                           r_rd_en_d;
   logic                           w_accept;
   logic                           w_rd_en;
   logic                           w_last;
   logic signed [LEN_DATA_OUT-1:0] w_acc;
   logic                           w_ovf;

   assign w_last = (r_cnt == r_len - LEN_ADDR'(1));

   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) r_state <= ST_IDLE;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_rd_en  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.START) begin
               w_accept = 1'b1;
               w_next   = (bus.VEC_LEN == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_rd_en = 1'b1;
            if (w_last) w_next = ST_DRAIN;
         end
         ST_DRAIN: w_next = ST_DONE;
         ST_DONE: begin
            if (bus.RESULT_READY) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         r_len     <= '0;
         r_cnt     <= '0;
         r_addr_d  <= '0;
         r_addr_w  <= '0;
         r_rd_en_d <= 1'b0;
      end else begin
         r_rd_en_d <= w_rd_en;
         if (w_accept) begin
            r_len    <= bus.VEC_LEN;
            r_cnt    <= '0;
            r_addr_d <= bus.BASE_ADDR_D;
            r_addr_w <= bus.BASE_ADDR_W;
         end else if (w_rd_en) begin
            r_cnt    <= r_cnt + LEN_ADDR'(1);
            r_addr_d <= r_addr_d + LEN_ADDR'(1);
            r_addr_w <= r_addr_w + LEN_ADDR'(1);
         end
      end
   end

   // Memories have fixed 1-cycle latency, so the delayed read strobe marks valid operands.
   mac_acc_unit #(
      .LEN_DATA_IN  (LEN_DATA_IN),
      .LEN_WEIGHT   (LEN_WEIGHT),
      .LEN_DATA_OUT (LEN_DATA_OUT)
   ) u_acc (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .i_clr     (w_accept),
      .i_en      (r_rd_en_d),
      .i_data    (bus.DATA_IN),
      .i_weight  (bus.WEIGHT_INPUT),
      .o_acc     (w_acc),
      .o_ovf     (w_ovf)
   );

   assign bus.BUSY         = (r_state != ST_IDLE);
   assign bus.RD_EN        = w_rd_en;
   assign bus.RD_ADDR_D    = r_addr_d;
   assign bus.RD_ADDR_W    = r_addr_w;
   assign bus.RESULT       = w_acc;
   assign bus.OVF          = w_ovf;
   assign bus.RESULT_VALID = (r_state == ST_DONE);

endmodule
